dmem_init_sequencer: RTL and testbench

// - Owns the single i281 data-memory port. After reset it copies the 16 hardcoded DMEM init bytes into DMEM.
// - After the copy it hands the port to the CPU.
// - On request it stalls the CPU and streams all 16 DMEM bytes out to the visualizer over a valid/ready port.
// - On request it reloads the init image.
// - Sits between DMEM_Hardcoded, the CPU datapath and DMEM.

---
 rtl/dmem_init_sequencer_pkg.sv | 26 ++
 rtl/dmem_init_sequencer_if.sv | 39 +++
 rtl/dmem_init_sequencer_init_byte_sel.sv | 18 +
 rtl/dmem_init_sequencer.sv | 127 ++++++++++++
 tb/tb_dmem_init_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_init_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// i281_dmem_pkg
// Shared constants and the sequencer state type for the i281 data-memory
// init/dump sequencer.
//   DEPTH     : number of DMEM bytes initialised and dumped
//   AW        : DMEM address width, log2(DEPTH)
//   DW        : DMEM data width
//   LAST_ADDR : highest DMEM address, ends both the init copy and the dump
//   state_t   : IDLE / INIT / RUN / DUMP
// ---------------------------------------------------------------------------
package i281_dmem_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DUMP
    } state_t;

endpackage

// File: rtl/dmem_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// dmem_init_sequencer_if
// Bundles the DMEM port and the visualizer dump stream owned by the sequencer.
//   dmem_we / dmem_addr / dmem_wdata : write port into DMEM
//   dmem_rdata                       : asynchronous DMEM read data
//   dump_valid / dump_ready          : valid/ready handshake to the visualizer
//   dump_addr / dump_data            : address and byte currently offered
// Modports:
//   master : sequencer side (drives DMEM controls and the dump stream)
//   slave  : memory/visualizer side
// ---------------------------------------------------------------------------
interface dmem_init_sequencer_if;
    import i281_dmem_pkg::*;

    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;

    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;

    modport master (
        output dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata,
        output dump_valid, dump_addr, dump_data,
        input  dump_ready
    );

    modport slave (
        input  dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata,
        input  dump_valid, dump_addr, dump_data,
        output dump_ready
    );

endinterface

// File: rtl/dmem_init_sequencer_init_byte_sel.sv
// ---------------------------------------------------------------------------
// init_byte_sel
// DEPTH:1 byte mux over the hardcoded init image.
//   init_data : packed init image, byte k on [DW*k+DW-1 : DW*k]
//   sel       : byte index
//   byte_out  : selected byte
// ---------------------------------------------------------------------------
module init_byte_sel
    import i281_dmem_pkg::*;
(
    input  logic [DEPTH*DW-1:0] init_data,
    input  logic [AW-1:0]       sel,
    output logic [DW-1:0]       byte_out
);

    assign byte_out = init_data[DW*sel +: DW];

endmodule

// File: rtl/dmem_init_sequencer.sv
// ---------------------------------------------------------------------------
// dmem_init_sequencer
// Owns the single i281 DMEM port. After reset it copies the init image into
// DMEM, then grants the port to the CPU. On request it stalls the CPU and
// streams all DMEM bytes to the visualizer, or rewrites the init image.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   init_data  : packed init image from DMEM_Hardcoded
//   reload_req : pulse, rewrite the init image (aborts a dump)
//   dump_req   : pulse, stream DMEM out (honoured only in RUN)
//   cpu_we / cpu_addr / cpu_wdata : CPU access, passed through in RUN
//   cpu_stall  : CPU must hold while the port is not granted
//   init_done  : image loaded at least once since reset
//   mem        : DMEM port and dump stream (master side)
// ---------------------------------------------------------------------------
module dmem_init_sequencer
    import i281_dmem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DEPTH*DW-1:0] init_data,
    input  logic                reload_req,
    input  logic                dump_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic                cpu_stall,
    output logic                init_done,
    dmem_init_sequencer_if.master mem
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] init_byte;

    init_byte_sel u_init_byte_sel (
        .init_data (init_data),
        .sel       (cnt),
        .byte_out  (init_byte)
    );

    // reload_req is checked first in every active state so it wins over a
    // simultaneous dump_req and over the end-of-copy/end-of-dump transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= INIT;
                    cnt   <= '0;
                end
                INIT: begin
                    if (reload_req) begin
                        cnt <= '0;
                    end else if (cnt == LAST_ADDR) begin
                        state     <= RUN;
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                RUN: begin
                    if (reload_req) begin
                        state <= INIT;
                        cnt   <= '0;
                    end else if (dump_req) begin
                        state <= DUMP;
                        cnt   <= '0;
                    end
                end
                DUMP: begin
                    if (reload_req) begin
                        state <= INIT;
                        cnt   <= '0;
                    end else if (mem.dump_ready) begin
                        if (cnt == LAST_ADDR) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign cpu_stall = (state != RUN);

    // Port mux: outputs are decoded from the registered state and counter;
    // only RUN passes the CPU access straight through.
    always_comb begin
        mem.dmem_we    = 1'b0;
        mem.dmem_addr  = '0;
        mem.dmem_wdata = '0;
        mem.dump_valid = 1'b0;
        mem.dump_addr  = '0;
        mem.dump_data  = mem.dmem_rdata;
        case (state)
            INIT: begin
                mem.dmem_we    = 1'b1;
                mem.dmem_addr  = cnt;
                mem.dmem_wdata = init_byte;
            end
            RUN: begin
                mem.dmem_we    = cpu_we;
                mem.dmem_addr  = cpu_addr;
                mem.dmem_wdata = cpu_wdata;
            end
            DUMP: begin
                mem.dmem_addr  = cnt;
                mem.dump_valid = 1'b1;
                mem.dump_addr  = cnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dmem_init_sequencer
// Self-checking bench for dmem_init_sequencer. Holds a DMEM array on the
// slave side of the interface and an expected-image array that follows the
// documented behaviour (init copy, CPU writes in RUN, reload restores image).
// ---------------------------------------------------------------------------
module tb_dmem_init_sequencer;
    import i281_dmem_pkg::*;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          expWe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic          expStall;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DEPTH*DW-1:0] initData;
    logic                reloadReq;
    logic                dumpReq;
    logic                cpuWe;
    logic [AW-1:0]       cpuAddr;
    logic [DW-1:0]       cpuWdata;
    logic                cpuStall;
    logic                initDone;
    logic                readyIn;

    logic [DW-1:0] ram       [DEPTH];
    logic [DW-1:0] initBytes [DEPTH];
    logic [DW-1:0] expMem    [DEPTH];
    vec_t          vecs      [5];

    int total = 0;
    int bad   = 0;

    dmem_init_sequencer_if bus();

    dmem_init_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_data  (initData),
        .reload_req (reloadReq),
        .dump_req   (dumpReq),
        .cpu_we     (cpuWe),
        .cpu_addr   (cpuAddr),
        .cpu_wdata  (cpuWdata),
        .cpu_stall  (cpuStall),
        .init_done  (initDone),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    // DMEM: synchronous write, asynchronous read
    always @(posedge clk) begin
        if (bus.dmem_we) ram[bus.dmem_addr] <= bus.dmem_wdata;
    end
    assign bus.dmem_rdata = ram[bus.dmem_addr];
    assign bus.dump_ready = readyIn;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic reload, input logic dump, input logic ready);
        cpuWe     = we;
        cpuAddr   = addr;
        cpuWdata  = wdata;
        reloadReq = reload;
        dumpReq   = dump;
        readyIn   = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_stall"},     32'(cpuStall),       32'd1);
        checkOutput({tag, "_we"},        32'(bus.dmem_we),    32'd0);
        checkOutput({tag, "_addr"},      32'(bus.dmem_addr),  32'd0);
        checkOutput({tag, "_wdata"},     32'(bus.dmem_wdata), 32'd0);
        checkOutput({tag, "_valid"},     32'(bus.dump_valid), 32'd0);
        checkOutput({tag, "_dump_addr"}, 32'(bus.dump_addr),  32'd0);
        checkOutput({tag, "_init_done"}, 32'(initDone),       32'd0);
    endtask

    // Called at the start of the first INIT cycle; optionally pulses dump_req
    // at write index dumpAt to show it is ignored.
    task automatic checkInitSequence(input string tag, input logic expDone, input int dumpAt);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, (k == dumpAt), 1'b1);
            #1;
            checkOutput($sformatf("%s_we_%0d", tag, k),    32'(bus.dmem_we),    32'd1);
            checkOutput($sformatf("%s_addr_%0d", tag, k),  32'(bus.dmem_addr),  32'(k));
            checkOutput($sformatf("%s_wdata_%0d", tag, k), 32'(bus.dmem_wdata), 32'(initBytes[k]));
            checkOutput($sformatf("%s_stall_%0d", tag, k), 32'(cpuStall),       32'd1);
            checkOutput($sformatf("%s_valid_%0d", tag, k), 32'(bus.dump_valid), 32'd0);
            checkOutput($sformatf("%s_done_%0d", tag, k),  32'(initDone),       32'(expDone));
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput({tag, "_end_done"},  32'(initDone),       32'd1);
        checkOutput({tag, "_end_stall"}, 32'(cpuStall),       32'd0);
        checkOutput({tag, "_end_valid"}, 32'(bus.dump_valid), 32'd0);
        for (int k = 0; k < DEPTH; k++) expMem[k] = initBytes[k];
    endtask

    task automatic runRandomCpu(input string tag, input int n);
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        for (int i = 0; i < n; i++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = AW'($urandom_range(0, DEPTH - 1));
            wdata = DW'($urandom_range(0, 255));
            applyStimulus(we, addr, wdata, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            #1;
            checkOutput($sformatf("%s_we_%0d", tag, i),    32'(bus.dmem_we),    32'(we));
            checkOutput($sformatf("%s_addr_%0d", tag, i),  32'(bus.dmem_addr),  32'(addr));
            checkOutput($sformatf("%s_wdata_%0d", tag, i), 32'(bus.dmem_wdata), 32'(wdata));
            checkOutput($sformatf("%s_stall_%0d", tag, i), 32'(cpuStall),       32'd0);
            if (we) expMem[addr] = wdata;
            tick();
        end
    endtask

    // Starts a dump from RUN (with a CPU write in the request cycle) and
    // drains it under the chosen backpressure pattern.
    task automatic runDump(input string tag, input logic randomReady);
        logic [DW-1:0] d;
        logic          rdy;
        int            accepted;
        int            cycles;
        d = DW'($urandom_range(0, 255));
        applyStimulus(1'b1, AW'(9), d, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput({tag, "_req_stall"}, 32'(cpuStall),    32'd0);
        checkOutput({tag, "_req_we"},    32'(bus.dmem_we), 32'd1);
        expMem[9] = d;
        tick();
        accepted = 0;
        cycles   = 0;
        while (accepted < DEPTH && cycles < 300) begin
            rdy = randomReady ? 1'($urandom_range(0, 1)) : (cycles % 3 == 0);
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, rdy);
            #1;
            checkOutput($sformatf("%s_valid_c%0d", tag, cycles), 32'(bus.dump_valid), 32'd1);
            checkOutput($sformatf("%s_stall_c%0d", tag, cycles), 32'(cpuStall),       32'd1);
            checkOutput($sformatf("%s_we_c%0d", tag, cycles),    32'(bus.dmem_we),    32'd0);
            checkOutput($sformatf("%s_addr_c%0d", tag, cycles),  32'(bus.dump_addr),  32'(accepted));
            checkOutput($sformatf("%s_data_c%0d", tag, cycles),  32'(bus.dump_data),  32'(expMem[accepted]));
            if (rdy) accepted++;
            tick();
            cycles++;
        end
        checkOutput({tag, "_bytes_accepted"}, 32'(accepted), 32'(DEPTH));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput({tag, "_end_stall"}, 32'(cpuStall),       32'd0);
        checkOutput({tag, "_end_valid"}, 32'(bus.dump_valid), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) initBytes[k] = (k < 5) ? DW'(7 - k) : '0;
        for (int k = 0; k < DEPTH; k++) initData[DW*k +: DW] = initBytes[k];

        vecs[0] = '{1'b1, 4'd5,  8'h2A, 1'b1, 4'd5,  8'h2A, 1'b0};
        vecs[1] = '{1'b0, 4'd3,  8'h55, 1'b0, 4'd3,  8'h55, 1'b0};
        vecs[2] = '{1'b1, 4'd15, 8'hC3, 1'b1, 4'd15, 8'hC3, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  8'h81, 1'b1, 4'd0,  8'h81, 1'b0};
        vecs[4] = '{1'b1, 4'd8,  8'hFF, 1'b1, 4'd8,  8'hFF, 1'b0};

        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetOutputs("reset");

        // release: one IDLE cycle, then the 16-byte copy
        rst_n = 1'b1;
        #1;
        checkOutput("idle_we",    32'(bus.dmem_we), 32'd0);
        checkOutput("idle_stall", 32'(cpuStall),    32'd1);
        tick();
        checkInitSequence("init", 1'b0, -1);

        // table-driven CPU passthrough
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d_we", i),    32'(bus.dmem_we),    32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0d_addr", i),  32'(bus.dmem_addr),  32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d_wdata", i), 32'(bus.dmem_wdata), 32'(vecs[i].expWdata));
            checkOutput($sformatf("vec%0d_stall", i), 32'(cpuStall),       32'(vecs[i].expStall));
            if (vecs[i].we) expMem[vecs[i].addr] = vecs[i].wdata;
            tick();
        end

        runRandomCpu("rnd1", 20);
        runDump("dump_bp", 1'b0);

        // abort a dump at address 6 after writing 0x2A to byte 5
        applyStimulus(1'b1, 4'd5, 8'h2A, 1'b0, 1'b0, 1'b0);
        expMem[5] = 8'h2A;
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("abort_addr_%0d", i), 32'(bus.dump_addr), 32'(i));
            checkOutput($sformatf("abort_data_%0d", i), 32'(bus.dump_data), 32'(expMem[i]));
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("abort_at_addr",  32'(bus.dump_addr),  32'd6);
        checkOutput("abort_at_valid", 32'(bus.dump_valid), 32'd1);
        tick();
        checkInitSequence("abort", 1'b1, -1);
        checkOutput("abort_byte5_restored", 32'(expMem[5]), 32'(initBytes[5]));
        runDump("after_abort", 1'b0);

        // reload and dump together: reload wins; dump_req during INIT ignored
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        tick();
        checkInitSequence("collide", 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("collide_post_valid_%0d", i), 32'(bus.dump_valid), 32'd0);
            checkOutput($sformatf("collide_post_stall_%0d", i), 32'(cpuStall),       32'd0);
            tick();
        end

        // async reset in the middle of INIT at cnt=9
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k <= 9; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("midrst_addr_%0d", k), 32'(bus.dmem_addr), 32'(k));
            if (k < 9) tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst_now");
        @(posedge clk);
        #1;
        checkResetOutputs("midrst_hold");
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_idle_we", 32'(bus.dmem_we), 32'd0);
        tick();
        checkInitSequence("restart", 1'b0, -1);

        runRandomCpu("rnd2", 30);
        runDump("dump_rnd", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
